// File: rtl/axi4l_led_pwm_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4l_pkg / axi4l_if : AXI4-Lite types and slave/master bundle        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi4l_led_pwm.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4l_led_pwm : N-channel LED PWM with AXI4-Lite register access      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module axi4l_led_pwm #(
  parameter int N   = 4,
  parameter int PW  = 8,
  parameter int PSW = 16
) (
  axi4l_if.slave       axi,
  output logic [N-1:0] led
);
  import axi4l_pkg::*;

  localparam logic [9:0] W_ENABLE   = 10'd0;
  localparam logic [9:0] W_PRESCALE = 10'd1;
  localparam logic [9:0] W_COUNT    = 10'd2;
  localparam logic [9:0] W_DUTY0    = 10'd4;

  logic clk;
  logic rst_n;
  assign clk   = axi.aclk;
  assign rst_n = axi.aresetn;

  logic           aw_held, w_held, bvalid_q, rvalid_q;
  logic [9:0]     aw_word_q;
  data_t          w_data_q, rdata_q;
  strb_t          w_strb_q;
  resp_t          bresp_q, rresp_q;
  logic [N-1:0]   enable_q;
  logic [PSW-1:0] prescale_q, pcnt_q;
  logic [PW-1:0]  count_q;
  logic [PW-1:0]  duty_q [N];

  logic       aw_fire, w_fire, ar_fire, do_write, tick;
  logic [9:0] wr_word, rd_word;
  data_t      wr_data, byte_mask, rd_data;
  strb_t      wr_strb;
  logic       wr_enable, wr_prescale, wr_err, rd_err;
  logic [N-1:0] wr_duty;

  // Ready outputs are held low during reset so every output reads 0.
  assign axi.awready = rst_n && !aw_held && !bvalid_q;
  assign axi.wready  = rst_n && !w_held && !bvalid_q;
  assign axi.arready = rst_n && (!rvalid_q || axi.rready);
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_fire  = axi.awvalid && axi.awready;
  assign w_fire   = axi.wvalid && axi.wready;
  assign ar_fire  = axi.arvalid && axi.arready;
  assign do_write = (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_word  = aw_held ? aw_word_q : axi.awaddr[11:2];
  assign wr_data  = w_held ? w_data_q : axi.wdata;
  assign wr_strb  = w_held ? w_strb_q : axi.wstrb;
  assign rd_word  = axi.araddr[11:2];
  assign byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

  assign wr_enable   = do_write && (wr_word == W_ENABLE);
  assign wr_prescale = do_write && (wr_word == W_PRESCALE);
  assign wr_err      = !(wr_enable || wr_prescale || (|wr_duty));
  assign tick        = (pcnt_q == prescale_q);

  always_comb begin
    wr_duty = '0;
    for (int i = 0; i < N; i++) begin
      wr_duty[i] = do_write && (wr_word == W_DUTY0 + 10'(i));
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_word == W_ENABLE) begin
      rd_data[N-1:0] = enable_q;
    end else if (rd_word == W_PRESCALE) begin
      rd_data[PSW-1:0] = prescale_q;
    end else if (rd_word == W_COUNT) begin
      rd_data[PW-1:0] = count_q;
    end else begin
      rd_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (rd_word == W_DUTY0 + 10'(i)) begin
          rd_data[PW-1:0] = duty_q[i];
          rd_err          = 1'b0;
        end
      end
    end
  end

  // Write channel: AW and W park independently until their partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held   <= 1'b0;
      aw_word_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (do_write) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_word_q <= axi.awaddr[11:2];
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end
      if (bvalid_q && axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q   <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
    end else begin
      if (wr_enable) begin
        enable_q <= (enable_q & ~byte_mask[N-1:0]) | (wr_data[N-1:0] & byte_mask[N-1:0]);
      end
      if (wr_prescale) begin
        prescale_q <= (prescale_q & ~byte_mask[PSW-1:0]) | (wr_data[PSW-1:0] & byte_mask[PSW-1:0]);
      end
      if (wr_prescale || tick) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + 1'b1;
      end
      if (tick) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) duty_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_duty[i]) begin
          duty_q[i] <= (duty_q[i] & ~byte_mask[PW-1:0]) | (wr_data[PW-1:0] & byte_mask[PW-1:0]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      for (int i = 0; i < N; i++) led[i] <= enable_q[i] && (count_q < duty_q[i]);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{axi.awaddr, axi.araddr, wr_data, byte_mask};
endmodule
`default_nettype wire

// File: tb/tb_axi4l_led_pwm.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi4l_led_pwm : scoreboard bench against a cycle-count PWM model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_axi4l_led_pwm;
  import axi4l_pkg::*;

  localparam int N   = 4;
  localparam int PW  = 8;
  localparam int PSW = 16;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axi4l_if axi (.aclk(clk), .aresetn(aresetn));
  logic [N-1:0] led;

  axi4l_led_pwm #(.N(N), .PW(PW), .PSW(PSW)) dut (.axi(axi), .led(led));

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wr_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rd_t;

  int checks = 0;
  int failures = 0;

  // Model: registers plus COUNT derived from elapsed clocks since the last PRESCALE write.
  logic [31:0] m_enable = '0;
  logic [31:0] m_prescale = '0;
  logic [31:0] m_duty [N] = '{default: '0};
  longint      cyc = 0, epoch = 0, base = 0;
  wr_t         wr_pend[$];
  logic [1:0]  b_exp[$];
  rd_t         rd_exp[$];
  logic [N-1:0] exp_led = '0;
  logic        prev_bvalid = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] m_count();
    return 32'((base + (cyc - epoch) / (longint'(m_prescale) + 1)) % (64'd1 << PW));
  endfunction

  function automatic rd_t m_read(input logic [31:0] a);
    rd_t r;
    logic [9:0] wd;
    wd = a[11:2];
    r.data = '0;
    r.resp = RESP_OKAY;
    if (wd == 0) r.data = m_enable;
    else if (wd == 1) r.data = m_prescale;
    else if (wd == 2) r.data = m_count();
    else if (wd >= 4 && wd < 10'(4 + N)) r.data = m_duty[wd - 4];
    else r.resp = RESP_SLVERR;
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input wr_t w, input int width);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (w.strb[b]) res[8*b +: 8] = w.data[8*b +: 8];
    return res & 32'((64'd1 << width) - 1);
  endfunction

  function automatic void m_write(input wr_t w);
    logic [9:0] wd;
    wd = w.addr[11:2];
    if (wd == 0) begin
      m_enable = lane_merge(m_enable, w, N);
      b_exp.push_back(RESP_OKAY);
    end else if (wd == 1) begin
      base  = longint'(m_count());
      epoch = cyc;
      m_prescale = lane_merge(m_prescale, w, PSW);
      b_exp.push_back(RESP_OKAY);
    end else if (wd >= 4 && wd < 10'(4 + N)) begin
      m_duty[wd - 4] = lane_merge(m_duty[wd - 4], w, PW);
      b_exp.push_back(RESP_OKAY);
    end else begin
      b_exp.push_back(RESP_SLVERR);
    end
  endfunction

  // Active edge: advance model time, check led, apply the write that raised bvalid.
  initial begin
    forever begin
      @(posedge clk);
      if (aresetn) cyc++;
      #1;
      chk("led", led, aresetn ? exp_led : '0);
      if (axi.bvalid && !prev_bvalid) begin
        chk("b_has_pending_write", wr_pend.size() > 0, 1);
        if (wr_pend.size() > 0) m_write(wr_pend.pop_front());
      end
      prev_bvalid = axi.bvalid;
    end
  end

  // Monitor on the opposite edge: pop on B/R handshakes, push read expectations at AR.
  initial begin
    rd_t r;
    logic [31:0] cnt;
    forever begin
      @(negedge clk);
      if (axi.bvalid && axi.bready) begin
        chk("b_exp_present", b_exp.size() > 0, 1);
        if (b_exp.size() > 0) chk("bresp", axi.bresp, b_exp.pop_front());
      end
      if (axi.rvalid && axi.rready) begin
        chk("r_exp_present", rd_exp.size() > 0, 1);
        if (rd_exp.size() > 0) begin
          r = rd_exp.pop_front();
          chk("rdata", axi.rdata, r.data);
          chk("rresp", axi.rresp, r.resp);
        end
      end
      if (axi.arvalid && axi.arready) rd_exp.push_back(m_read(axi.araddr));
      cnt = m_count();
      for (int i = 0; i < N; i++) exp_led[i] = m_enable[i] && (cnt < m_duty[i]);
    end
  end

  initial begin
    forever begin
      @(negedge aresetn);
      m_enable = '0;
      m_prescale = '0;
      for (int i = 0; i < N; i++) m_duty[i] = '0;
      cyc = 0; epoch = 0; base = 0;
      wr_pend.delete(); b_exp.delete(); rd_exp.delete();
      exp_led = '0;
      prev_bvalid = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    int  aw_at, w_at, k;
    bit  aw_done, w_done, aw_f, w_f;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; k = 0;
    wr_pend.push_back('{addr: a, data: d, strb: s});
    while (!(aw_done && w_done)) begin
      if (k == aw_at) begin axi.awaddr = a; axi.awvalid = 1'b1; end
      if (k == w_at) begin axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1; end
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      @(posedge clk); #2;
      if (aw_f) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (w_f) begin axi.wvalid = 1'b0; w_done = 1; end
      k++;
      if (k > 60) begin
        chk("write_timeout", 0, 1);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        break;
      end
    end
    if (aw_done && w_done) chk("bvalid_after_last_handshake", axi.bvalid, 1);
  endtask

  task automatic wait_b();
    int k;
    k = 0;
    while (!(axi.bvalid && axi.bready)) begin
      @(posedge clk); #2;
      k++;
      if (k > 50) begin chk("b_timeout", 0, 1); return; end
    end
    @(posedge clk); #2;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int k;
    bit f;
    k = 0;
    if (hold > 0) axi.rready = 1'b0;
    axi.araddr = a; axi.arvalid = 1'b1;
    forever begin
      f = axi.arvalid && axi.arready;
      @(posedge clk); #2;
      k++;
      if (f) begin axi.arvalid = 1'b0; break; end
      if (k > 50) begin chk("ar_timeout", 0, 1); axi.arvalid = 1'b0; return; end
    end
    for (int h = 0; h < hold; h++) begin
      chk("rvalid_held", axi.rvalid, 1);
      chk("r_exp_present_hold", rd_exp.size() > 0, 1);
      if (rd_exp.size() > 0) chk("rdata_frozen", axi.rdata, rd_exp[0].data);
      @(posedge clk); #2;
    end
    axi.rready = 1'b1;
    k = 0;
    while (!(axi.rvalid && axi.rready)) begin
      @(posedge clk); #2;
      k++;
      if (k > 50) begin chk("r_timeout", 0, 1); return; end
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int          sel, hi, lead;
    logic [31:0] a, d;
    logic [3:0]  s;
    axi.awaddr = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    axi.araddr = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", led, 0);
    chk("reset_bvalid", axi.bvalid, 0);
    chk("reset_rvalid", axi.rvalid, 0);
    #2 aresetn = 1'b1;
    #1;
    chk("rel_awready", axi.awready, 1);
    chk("rel_wready", axi.wready, 1);
    chk("rel_arready", axi.arready, 1);

    // Reset values, COUNT sampled on the very first edge.
    do_read(32'h008, 0);
    do_read(32'h000, 0);
    do_read(32'h004, 0);
    do_read(32'h010, 0);

    // W leads AW; 50% duty on channel 1 at full clock rate.
    do_write(32'h014, 32'h80, 4'hF, 3); wait_b();
    do_write(32'h000, 32'h2, 4'hF, -2); wait_b();
    do_write(32'h004, 32'h0, 4'hF, 0); wait_b();
    cycles(5);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      if (led[1]) hi++;
      cycles(1);
    end
    chk("led1_high_per_256", hi, 128);

    // Error paths leave state untouched.
    do_write(32'h00C, 32'hFFFF_FFFF, 4'hF, 0); wait_b();
    do_read(32'h100, 0);
    do_write(32'h008, 32'h55, 4'hF, 1); wait_b();
    do_read(32'h000, 0);
    do_read(32'h014, 0);

    // Byte strobes.
    do_write(32'h018, 32'hA5, 4'h0, 0); wait_b();
    do_write(32'h004, 32'h1234, 4'h2, 0); wait_b();
    do_read(32'h004, 0);
    do_write(32'h004, 32'h0, 4'hF, 0); wait_b();

    // Back-pressured B channel.
    axi.bready = 1'b0;
    do_write(32'h010, 32'h40, 4'hF, 0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_bvalid", axi.bvalid, 1);
      chk("bp_bresp", axi.bresp, RESP_OKAY);
      chk("bp_awready", axi.awready, 0);
      chk("bp_wready", axi.wready, 0);
      cycles(1);
    end
    axi.bready = 1'b1;
    cycles(1);
    chk("bp_bvalid_cleared", axi.bvalid, 0);
    chk("bp_awready_resumed", axi.awready, 1);

    // Same-edge read and write of DUTY[0] returns the old value.
    axi.araddr = 32'h010; axi.arvalid = 1'b1;
    axi.awaddr = 32'h010; axi.awvalid = 1'b1;
    axi.wdata = 32'h77; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    wr_pend.push_back('{addr: 32'h010, data: 32'h77, strb: 4'hF});
    cycles(1);
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    cycles(3);
    do_read(32'h010, 0);

    // Prescaled counting across a full COUNT wrap; DUTY[0]=0 keeps led[0] off.
    do_write(32'h004, 32'h3, 4'hF, 0); wait_b();
    do_write(32'h000, 32'hF, 4'hF, 0); wait_b();
    do_write(32'h010, 32'h0, 4'hF, -1); wait_b();
    do_read(32'h008, 6);
    for (int c = 0; c < 12; c++) begin
      do_read(32'h008, 0);
      cycles(80 + c);
    end

    // Randomised traffic.
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: a = 32'h000;
        1: a = 32'h004;
        2: a = 32'h008;
        3: a = 32'h00C;
        4, 5, 6, 7: a = 32'h010 + 32'(4 * (sel - 4));
        8: a = 32'h100;
        default: a = 32'h020;
      endcase
      a = a | ($urandom & 32'hFFFF_F000);
      d = $urandom;
      if (a[11:2] == 10'd1) d = $urandom_range(0, 3);
      s = 4'($urandom);
      lead = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, s, lead);
        wait_b();
      end else begin
        do_read(a, int'($urandom_range(0, 2)));
      end
      cycles(int'($urandom_range(0, 20)));
    end

    // Reset while a B response is pending and an AW is waiting.
    axi.bready = 1'b0;
    do_write(32'h01C, 32'h44, 4'hF, 0);
    axi.awaddr = 32'h018; axi.awvalid = 1'b1;
    axi.wdata = 32'h99; axi.wstrb = 4'hF;
    cycles(2);
    #1 aresetn = 1'b0;
    #1;
    chk("arst_led", led, 0);
    chk("arst_bvalid", axi.bvalid, 0);
    chk("arst_rvalid", axi.rvalid, 0);
    chk("arst_awready", axi.awready, 0);
    chk("arst_wready", axi.wready, 0);
    chk("arst_arready", axi.arready, 0);
    axi.awvalid = 1'b0;
    axi.bready = 1'b1;
    @(posedge clk);
    #3 aresetn = 1'b1;
    #1;
    chk("rel2_awready", axi.awready, 1);
    chk("rel2_wready", axi.wready, 1);
    chk("rel2_arready", axi.arready, 1);
    for (int c = 0; c < 5; c++) begin
      cycles(1);
      chk("no_b_after_reset", axi.bvalid, 0);
    end
    do_read(32'h01C, 0);
    do_read(32'h018, 0);
    do_read(32'h000, 0);
    cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi4l_led_pwm.md
AXI4L_LED_PWM -- requirements
Module: axi4l_led_pwm

Interface
REQ-001 Parameter N, default 4, meaning number of LED channels; legal range 1..32.
REQ-002 Parameter PW, default 8, meaning PWM duty and counter width in bits; legal range 2..16.
REQ-003 Parameter PSW, default 16, meaning prescaler width in bits; legal range 1..32.
REQ-004 axi.aclk  input  1  the single clock.
REQ-005 axi.aresetn  input  1  reset, asynchronous, active-low.
REQ-006 led  output  N  LED drive, one bit per channel, registered.
REQ-007 axi  axi4l_if.slave  -  AXI4-Lite slave port: AW, W, B, AR and R channels with axi4l_pkg addr_t, data_t and resp_t types; wstrb is honoured.

Function
REQ-008 The register map SHALL decode axi.awaddr[11:2] and axi.araddr[11:2] only; the upper address bits are ignored.
- 0x000 ENABLE: RW, bits [N-1:0].
- 0x004 PRESCALE: RW, bits [PSW-1:0].
- 0x008 COUNT: RO, bits [PW-1:0].
- 0x010+4*i DUTY[i]: RW, bits [PW-1:0], for i=0..N-1.
REQ-009 Unused bits SHALL read 0; unmapped addresses SHALL respond SLVERR, ignore the write and return rdata 0; a write to COUNT SHALL respond SLVERR and have no effect.
REQ-010 RW register writes SHALL update only the bytes whose wstrb bit is 1.
REQ-011 AW and W SHALL be accepted independently; each is latched in a one-entry holding register.
- awready=1 iff no address is held and no B response is pending.
- wready=1 iff no data is held and no B response is pending.
REQ-012 The register write and bvalid assertion SHALL occur on the clock edge after both address and data are available.
- Same-cycle AW+W: bvalid=1 in cycle +1.
REQ-013 bvalid SHALL stay 1 with bresp stable until bready=1; then it clears on that edge, and AW/W acceptance resumes in the next cycle.
REQ-014 arready SHALL equal (!rvalid || rready); rdata and rresp SHALL be captured at the AR handshake and held stable while rvalid=1.
- rvalid=1 in cycle +1 after the AR handshake.
REQ-015 A read and a write to the same register completing on the same edge SHALL return the pre-write value.
REQ-016 The prescaler counter SHALL count 0..PRESCALE and generate a one-cycle tick when it equals PRESCALE, then return to 0.
- PRESCALE=0 gives a tick every clock.
- Any write to PRESCALE resets the prescaler counter to 0.
REQ-017 COUNT SHALL increment by 1 on each tick and wrap from 2^PW-1 to 0 (modulo 2^PW).
REQ-018 On each clock edge, led[i] SHALL be loaded with ENABLE[i] && (COUNT < DUTY[i]), evaluated as an unsigned comparison.
- DUTY=0: always off.
- DUTY=2^PW-1: on for 2^PW-1 of every 2^PW counts.
REQ-019 A change to DUTY or ENABLE SHALL take effect on led in the second cycle after the write edge; there is no wait for a PWM period boundary.

Reset
REQ-020 While axi.aresetn=0, and immediately on its assertion, the following SHALL be 0:
- led, ENABLE, PRESCALE, every DUTY[i], COUNT and the prescaler counter;
- bvalid, rvalid and the AW/W holding flags.
REQ-021 A reset asserted mid-transaction SHALL discard any held address/data and pending responses with no register update; after release, awready=wready=arready=1.

Verification
REQ-022 Reset release, then reads of 0x000, 0x004, 0x008 and 0x010 -> each rdata=0, rresp=OKAY, led=0.
REQ-023 W sent 3 cycles before AW (DUTY[1]=0x80, ENABLE=0x2, PRESCALE=0) -> bvalid is 1 the cycle after AW; with PW=8, led[1] is high 128 of every 256 clocks.
REQ-024 Write 0x0C, read 0x100, write to 0x008 -> each gives SLVERR; all registers are unchanged; the read returns rdata=0.
REQ-025 bready held 0 for 5 cycles after a write -> bvalid and bresp are stable; awready=wready=0 throughout; a new AW is accepted the cycle after bready=1.
REQ-026 PRESCALE=3 -> COUNT increments every 4 clocks and wraps from 0xFF to 0x00; rready held low keeps rdata frozen; DUTY=0 with ENABLE=1 -> led stays 0.
REQ-027 aresetn pulsed low while AW is held and bvalid is pending -> all outputs are 0 asynchronously; after release, no B response is issued and the target register remains 0.
